// File: rtl/flex_counter_mc.sv
// rtl/flex_counter_mc.sv - multi-channel up/down flex counter with load, one-shot and rollover pulse
module flex_counter_mc #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              count_down,
  input  logic [NUM_CH-1:0]              one_shot,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              rollover_pulse,
  output logic [NUM_CH-1:0]              done
);

  localparam int B = NUM_CNT_BITS;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [B-1:0] cnt_q;
    logic         flag_q;
    logic         pulse_q;
    logic         done_q;
    logic [B-1:0] rv;
    logic [B-1:0] lv;
    logic [B-1:0] term;
    logic [B-1:0] nxt;
    logic         nxt_done;
    logic         nxt_pulse;
    logic         nxt_flag;

    assign rv   = rollover_val[gi*B +: B];
    assign lv   = load_val[gi*B +: B];
    // Down-counting channels terminate at 1 so that 0 stays the cleared/idle value.
    assign term = count_down[gi] ? B'(1) : rv;

    // Next count, done and pulse for this channel in priority order.
    always_comb begin
      nxt       = cnt_q;
      nxt_done  = done_q;
      nxt_pulse = 1'b0;
      if (clear[gi]) begin
        nxt      = '0;
        nxt_done = 1'b0;
      end else if (load[gi]) begin
        nxt      = lv;
        nxt_done = 1'b0;
      end else if (count_enable[gi]) begin
        if (rv == '0) begin
          // A zero rollover value is not a usable range; freeze the count.
          nxt = cnt_q;
        end else if (done_q) begin
          nxt = cnt_q;
        end else if (one_shot[gi] && (cnt_q == term)) begin
          nxt_done = 1'b1;
        end else if (!count_down[gi]) begin
          // >= also catches a count left above R by a load or an R change.
          if (cnt_q >= rv) begin
            nxt       = B'(1);
            nxt_pulse = 1'b1;
          end else begin
            nxt = cnt_q + B'(1);
          end
        end else if (cnt_q == B'(1)) begin
          nxt       = rv;
          nxt_pulse = 1'b1;
        end else if (cnt_q == '0) begin
          // Leaving the cleared state is not a wrap, so no pulse.
          nxt = rv;
        end else begin
          nxt = cnt_q - B'(1);
        end
      end
      nxt_flag = (nxt == term) && (rv != '0);
    end

    // Register the channel state and all of its outputs.
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q   <= '0;
        flag_q  <= 1'b0;
        pulse_q <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        cnt_q   <= nxt;
        flag_q  <= nxt_flag;
        pulse_q <= nxt_pulse;
        done_q  <= nxt_done;
      end
    end

    assign count_out[gi*B +: B] = cnt_q;
    assign rollover_flag[gi]    = flag_q;
    assign rollover_pulse[gi]   = pulse_q;
    assign done[gi]             = done_q;
  end

endmodule

// File: tb/tb_flex_counter_mc.sv
// tb/tb_flex_counter_mc.sv - randomized and directed bench for flex_counter_mc against a behavioural model
module tb_flex_counter_mc;

  localparam int B      = 4;
  localparam int NUM_CH = 2;

  logic                    clk = 1'b0;
  logic                    n_rst;
  logic [NUM_CH-1:0]       clear;
  logic [NUM_CH-1:0]       count_enable;
  logic [NUM_CH-1:0]       count_down;
  logic [NUM_CH-1:0]       one_shot;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*B-1:0]     load_val;
  logic [NUM_CH*B-1:0]     rollover_val;
  logic [NUM_CH*B-1:0]     count_out;
  logic [NUM_CH-1:0]       rollover_flag;
  logic [NUM_CH-1:0]       rollover_pulse;
  logic [NUM_CH-1:0]       done;

  int n_checks = 0;
  int n_fails  = 0;

  int m_cnt   [NUM_CH];
  int m_flag  [NUM_CH];
  int m_pulse [NUM_CH];
  int m_done  [NUM_CH];

  flex_counter_mc #(.NUM_CNT_BITS(B), .NUM_CH(NUM_CH)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (clear),
    .count_enable   (count_enable),
    .count_down     (count_down),
    .one_shot       (one_shot),
    .load           (load),
    .load_val       (load_val),
    .rollover_val   (rollover_val),
    .count_out      (count_out),
    .rollover_flag  (rollover_flag),
    .rollover_pulse (rollover_pulse),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rval(input int ch);
    return int'(rollover_val[ch*B +: B]);
  endfunction

  task automatic set_r(input int ch, input int v);
    rollover_val[ch*B +: B] = v[B-1:0];
  endtask

  task automatic set_lv(input int ch, input int v);
    load_val[ch*B +: B] = v[B-1:0];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_flag[i] = 0; m_pulse[i] = 0; m_done[i] = 0;
    end
  endtask

  // Apply the counter rules to every channel using the inputs seen at this edge.
  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      int r;
      int t;
      r = rval(i);
      t = count_down[i] ? 1 : r;
      m_pulse[i] = 0;
      if (clear[i]) begin
        m_cnt[i] = 0; m_done[i] = 0;
      end else if (load[i]) begin
        m_cnt[i] = int'(load_val[i*B +: B]); m_done[i] = 0;
      end else if (count_enable[i] && r != 0 && m_done[i] == 0) begin
        if (one_shot[i] && m_cnt[i] == t) begin
          m_done[i] = 1;
        end else if (!count_down[i]) begin
          if (m_cnt[i] >= r) begin m_cnt[i] = 1; m_pulse[i] = 1; end
          else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          case (m_cnt[i])
            1:       begin m_cnt[i] = r; m_pulse[i] = 1; end
            0:       m_cnt[i] = r;
            default: m_cnt[i] = m_cnt[i] - 1;
          endcase
        end
      end
      m_flag[i] = (m_cnt[i] == t && r != 0) ? 1 : 0;
    end
  endtask

  task automatic compare_all(input string where);
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("%s cnt%0d", where, i),   int'(count_out[i*B +: B]), m_cnt[i]);
      check($sformatf("%s flag%0d", where, i),  int'(rollover_flag[i]),    m_flag[i]);
      check($sformatf("%s pulse%0d", where, i), int'(rollover_pulse[i]),   m_pulse[i]);
      check($sformatf("%s done%0d", where, i),  int'(done[i]),             m_done[i]);
    end
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    model_step();
    #1;
    compare_all(where);
  endtask

  task automatic idle_inputs();
    clear = '0; count_enable = '0; count_down = '0; one_shot = '0; load = '0;
    load_val = '0; rollover_val = '0;
  endtask

  initial begin
    idle_inputs();
    n_rst = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Up count, R=5, channel 1 idle.
    set_r(0, 5); count_enable[0] = 1'b1;
    for (int k = 0; k < 6; k++) cycle("up");
    check("up_wrap_cnt", int'(count_out[0 +: B]), 1);
    check("up_wrap_pulse", int'(rollover_pulse[0]), 1);
    for (int k = 0; k < 4; k++) cycle("up");

    // Down wrap from a cleared count, R=3.
    clear[0] = 1'b1; cycle("down_clr"); clear[0] = 1'b0;
    set_r(0, 3); count_down[0] = 1'b1;
    cycle("down");
    check("down_from0_cnt", int'(count_out[0 +: B]), 3);
    check("down_from0_pulse", int'(rollover_pulse[0]), 0);
    for (int k = 0; k < 8; k++) cycle("down");

    // One-shot up, R=4, then clear.
    clear[0] = 1'b1; cycle("os_clr"); clear[0] = 1'b0;
    count_down[0] = 1'b0; one_shot[0] = 1'b1; set_r(0, 4);
    for (int k = 0; k < 7; k++) cycle("oneshot");
    check("os_hold_cnt", int'(count_out[0 +: B]), 4);
    check("os_done", int'(done[0]), 1);
    clear[0] = 1'b1; cycle("os_clear"); clear[0] = 1'b0; one_shot[0] = 1'b0;

    // Priority: clear beats load beats enable; then overrun on a loaded 7 with R=5.
    set_r(0, 5); set_lv(0, 7); clear[0] = 1'b1; load[0] = 1'b1; count_enable[0] = 1'b1;
    cycle("prio_all");
    check("prio_clear_cnt", int'(count_out[0 +: B]), 0);
    clear[0] = 1'b0; count_enable[0] = 1'b0;
    cycle("prio_load");
    load[0] = 1'b0; count_enable[0] = 1'b1;
    cycle("prio_overrun");
    check("overrun_cnt", int'(count_out[0 +: B]), 1);
    check("overrun_pulse", int'(rollover_pulse[0]), 1);

    // Independent channels, then ch1 R dropped to 0.
    clear = '1; cycle("ind_clr"); clear = '0;
    set_r(0, 15); set_r(1, 2); count_down = 2'b10; count_enable = 2'b11;
    for (int k = 0; k < 20; k++) cycle("indep");
    set_r(1, 0);
    for (int k = 0; k < 4; k++) cycle("r_zero");
    check("r_zero_flag1", int'(rollover_flag[1]), 0);

    // Asynchronous reset in the middle of a cycle.
    set_r(1, 2);
    for (int k = 0; k < 3; k++) cycle("pre_rst");
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    @(negedge clk);
    n_rst = 1'b1;
    idle_inputs();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        clear[i]        = ($urandom_range(0, 24) == 0);
        load[i]         = ($urandom_range(0, 14) == 0);
        count_enable[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) count_down[i] = ~count_down[i];
        if ($urandom_range(0, 29) == 0) one_shot[i]   = ~one_shot[i];
        if ($urandom_range(0, 24) == 0) set_r(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)));
        set_lv(i, int'($urandom_range(0, 15)));
      end
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/flex_counter_mc.md
Name: flex_counter_mc

Overview:
- Multi-channel, parametrised successor to the single flex counter.
- NUM_CH independent counters share one clock and reset. Each channel adds the following over the single counter:
  - up/down direction
  - synchronous load
  - one-shot (stop-at-terminal) mode
  - single-cycle rollover pulse
  - sticky done flag
- Used by the accelerator datapath for sample-index, tap-index and wait-state timing in a single instance.

Parameters:
- NUM_CNT_BITS, 4, width of every channel's counter.
- NUM_CH, 2, number of independent channels (1..8).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  NUM_CH  per-channel synchronous clear.
- count_enable  input  NUM_CH  per-channel count enable.
- count_down  input  NUM_CH  per-channel direction: 1 = down, 0 = up.
- one_shot  input  NUM_CH  per-channel mode: 1 = stop at terminal, 0 = wrap.
- load  input  NUM_CH  per-channel synchronous load strobe.
- load_val  input  NUM_CH*NUM_CNT_BITS  load values; channel i uses bits [i*NUM_CNT_BITS +: NUM_CNT_BITS].
- rollover_val  input  NUM_CH*NUM_CNT_BITS  per-channel rollover values, same packing.
- count_out  output  NUM_CH*NUM_CNT_BITS  registered counts, same packing.
- rollover_flag  output  NUM_CH  registered; high while the count equals the terminal value.
- rollover_pulse  output  NUM_CH  registered; one-cycle pulse after a wrap.
- done  output  NUM_CH  registered, sticky; one-shot terminal reached.

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-low (n_rst). On reset, every count_out, rollover_flag, rollover_pulse and done bit is 0.
- Channels are fully independent; all logic below is per channel i. R = rollover_val[i], C = current count.
- Terminal value: T = R when count_down=0; T = 1 when count_down=1.
- Next-state priority, highest first:
  - clear: next = 0; done <= 0.
  - load: next = load_val; done <= 0.
  - enable with R == 0: hold (R=0 is illegal); no pulse.
  - enable with done == 1: hold.
  - enable with C == T and one_shot == 1: hold; done <= 1; no pulse.
  - enable, up mode, wrap: if C == R, or C > R (overrun after load or R change), next = 1 and rollover_pulse <= 1.
  - enable, up mode, otherwise: next = C + 1.
  - enable, down mode, wrap: if C == 1, next = R and rollover_pulse <= 1.
  - enable, down mode, from 0: if C == 0 (post-clear), next = R with no pulse.
  - enable, down mode, otherwise: next = C - 1.
  - no enable: hold.
- Outputs (registered; no combinational input-to-output path):
  - rollover_flag <= (next == T) && (R != 0).
  - rollover_pulse is 0 in every cycle not listed as a wrap above.
- Latency: all effects are visible one clock after the sampling edge.
- Arithmetic: unsigned, NUM_CNT_BITS wide. The modulo-2^NUM_CNT_BITS wraparound is unreachable because of the C > R rule.
- Direction change mid-count: takes effect on the next enabled cycle; T is re-evaluated immediately, so rollover_flag follows next and the new T.
- Changing R mid-count is legal; the rules above apply to the new R.
- Reset mid-operation: all state clears asynchronously. The first count after n_rst deasserts needs count_enable sampled at a clk edge.

Test Plan:
- Reset/basic up, B=4, R=5, ch0 enabled continuously:
  - counts 0,1,2,3,4,5,1,2...
  - rollover_flag high exactly while count=5.
  - rollover_pulse high one cycle while count=1 after the wrap.
  - ch1 idle stays 0.
- Down wrap, R=3, count_down=1, from 0:
  - counts 3,2,1,3,2,1...
  - flag high when count=1; pulse only when 1→3, not on 0→3.
- One-shot up, R=4, one_shot=1:
  - counts 1,2,3,4 then holds 4.
  - done=1 from the cycle after the enable at 4; no pulse.
  - clear → count=0, done=0.
- Priority: assert clear, load (load_val=7) and enable in the same cycle → count=0.
  - Next cycle load only → count=7.
  - With R=5, up, enabled → 1 with pulse (overrun).
- Independence and edges:
  - ch0 R=15 up vs ch1 R=2 down, both enabled → ch0 wraps 15→1 while ch1 cycles 2,1,2.
  - ch1 R changed to 0 → ch1 holds, flag 0.
  - Async n_rst low mid-count → all outputs 0 before the next clk edge.
